// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants and frame-FSM state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_NO_KEY       = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Bundle of raw PS/2 pins and the decoded scan-code outputs of the receiver.
interface ps2_keyboard_rx_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       key_release;
    logic       frame_err;

    // Receiver side: consumes the pins, produces the scan-code stream.
    modport master (
        input  ps2_clk,
        input  ps2_data,
        output code,
        output code_valid,
        output key_release,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  code,
        input  code_valid,
        input  key_release,
        input  frame_err
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 clock, rejects glitches shorter than FILTER_LEN
// samples, and emits a one-cycle strobe on each filtered falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q,  filt_d;
    logic          fall_q,  fall_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = ps2_clk;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the run count.
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and resolves make/break/
// extended sequences into a held scan code for the glyph decoder.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    ps2_keyboard_rx_if.master   bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data_s1_q, data_s1_d;
    logic          data_s2_q, data_s2_d;
    ps2_state_e    state_q,   state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic          parity_q,  parity_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          ext_q,     ext_d;
    logic          brk_q,     brk_d;
    logic [7:0]    code_q,    code_d;
    logic          code_valid_q,  code_valid_d;
    logic          key_release_q, key_release_d;
    logic          frame_err_q,   frame_err_d;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (bus.ps2_clk),
        .fall    (fall)
    );

    always_comb begin
        data_s1_d     = bus.ps2_data;
        data_s2_d     = data_s1_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        tmo_d         = tmo_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        code_d        = code_q;
        code_valid_d  = 1'b0;
        key_release_d = 1'b0;
        frame_err_d   = 1'b0;

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_s2_q;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    // Odd parity across the 8 data bits plus the parity bit.
                    if (data_s2_q && (^{shift_q, parity_q})) begin
                        if (shift_q == PS2_EXT_PREFIX) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BREAK_PREFIX) begin
                            brk_d = 1'b1;
                        end else if (ext_q) begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end else if (brk_q) begin
                            key_release_d = 1'b1;
                            brk_d         = 1'b0;
                            if (shift_q == code_q) begin
                                code_d = PS2_NO_KEY;
                            end
                        end else begin
                            code_d       = shift_q;
                            code_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled frame is abandoned along with any pending prefix.
            if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
                shift_d     = '0;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s1_q     <= 1'b1;
            data_s2_q     <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tmo_q         <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            code_q        <= PS2_NO_KEY;
            code_valid_q  <= 1'b0;
            key_release_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            data_s1_q     <= data_s1_d;
            data_s2_q     <= data_s2_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tmo_q         <= tmo_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            code_q        <= code_d;
            code_valid_q  <= code_valid_d;
            key_release_q <= key_release_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.code_valid  = code_valid_q;
    assign bus.key_release = key_release_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-bangs PS/2 frames and checks the
// held code and pulse counts after each step.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 500;
    localparam int HALF           = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cv_cnt = 0, kr_cnt = 0, fe_cnt = 0, cv_cyc = 0, excl_viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.code_valid === 1'b1) begin
                cv_cnt = cv_cnt + 1;
                cv_cyc = cyc;
            end
            if (bus.key_release === 1'b1) kr_cnt = kr_cnt + 1;
            if (bus.frame_err === 1'b1)   fe_cnt = fe_cnt + 1;
            if ((bus.code_valid & bus.key_release) | (bus.code_valid & bus.frame_err) |
                (bus.key_release & bus.frame_err))
                excl_viol = excl_viol + 1;
        end
    end

    int nvec = 0, nerr = 0;
    int last_fall_cyc = 0;
    int cv0, kr0, fe0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        cv0 = cv_cnt;
        kr0 = kr_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic chk_deltas(input string tag, input int dcv, input int dkr, input int dfe);
        chk({tag, ".code_valid_pulses"},  cv_cnt - cv0, dcv);
        chk({tag, ".key_release_pulses"}, kr_cnt - kr0, dkr);
        chk({tag, ".frame_err_pulses"},   fe_cnt - fe0, dfe);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        bus.ps2_data = b;
        wait_cyc(HALF / 2);
        bus.ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
        if (glitch) begin
            wait_cyc(10);
            bus.ps2_clk = 1'b0;
            wait_cyc(FILTER_LEN - 1);
            bus.ps2_clk = 1'b1;
        end
        wait_cyc(HALF / 2);
    endtask

    // Frame bits LSB first: start, 8 data, odd parity, stop.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits,
                              input int glitch_at);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
        wait_cyc(10);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(4);
        chk("rst.code_during", bus.code, 8'h00);
        rst = 1'b0;
        wait_cyc(5);
        chk("rst.code",        bus.code,        8'h00);
        chk("rst.code_valid",  bus.code_valid,  1'b0);
        chk("rst.key_release", bus.key_release, 1'b0);
        chk("rst.frame_err",   bus.frame_err,   1'b0);

        // Make 1C
        snap();
        send(8'h1C);
        chk("make1C.code", bus.code, 8'h1C);
        chk_deltas("make1C", 1, 0, 0);
        chk("make1C.latency", cv_cyc - last_fall_cyc, FILTER_LEN + 3);

        // Break of held key
        snap();
        send(8'hF0);
        chk("brk1C.after_F0_code", bus.code, 8'h1C);
        send(8'h1C);
        chk("brk1C.code", bus.code, 8'h00);
        chk_deltas("brk1C", 0, 1, 0);

        // Break of a different key
        send(8'h1C);
        send(8'h32);
        chk("make32.code", bus.code, 8'h32);
        snap();
        send(8'hF0);
        send(8'h32);
        chk("brk32.code", bus.code, 8'h00);
        chk_deltas("brk32", 0, 1, 0);
        snap();
        send(8'hF0);
        send(8'h1C);
        chk("brk1C_late.code", bus.code, 8'h00);
        chk_deltas("brk1C_late", 0, 1, 0);

        // Extended keys ignored while 15 is held
        send(8'h15);
        chk("make15.code", bus.code, 8'h15);
        snap();
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("ext75.code", bus.code, 8'h15);
        chk_deltas("ext75", 0, 0, 0);

        // Parity error
        snap();
        send_frame(8'h24, 1'b1, 11, -1);
        chk("parerr.code", bus.code, 8'h15);
        chk_deltas("parerr", 0, 0, 1);

        // Partial frame followed by idle line
        snap();
        send_frame(8'h24, 1'b0, 5, -1);
        wait_cyc(TIMEOUT_CYCLES + 100);
        chk("timeout.code", bus.code, 8'h15);
        chk_deltas("timeout", 0, 0, 1);
        snap();
        send(8'h24);
        chk("after_tmo24.code", bus.code, 8'h24);
        chk_deltas("after_tmo24", 1, 0, 0);

        // Short glitch on ps2_clk mid-frame
        snap();
        send_frame(8'h2B, 1'b0, 11, 3);
        chk("glitch2B.code", bus.code, 8'h2B);
        chk_deltas("glitch2B", 1, 0, 0);

        // Reset during bit 4
        snap();
        send_frame(8'h5A, 1'b0, 4, -1);
        bus.ps2_data = 1'b1;
        wait_cyc(HALF / 2);
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF / 2);
        rst = 1'b1;
        wait_cyc(3);
        chk("midrst.code",        bus.code,        8'h00);
        chk("midrst.code_valid",  bus.code_valid,  1'b0);
        chk("midrst.key_release", bus.key_release, 1'b0);
        chk("midrst.frame_err",   bus.frame_err,   1'b0);
        bus.ps2_clk = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(20);
        chk_deltas("midrst", 0, 0, 0);
        snap();
        send(8'h1D);
        chk("post_rst1D.code", bus.code, 8'h1D);
        chk_deltas("post_rst1D", 1, 0, 0);

        chk("exclusivity.violations", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives the serial PS/2 keyboard stream, deframes 11-bit frames, and resolves make/break/extended sequences into a held 8-bit scan code. Sits directly upstream of the scan-code-to-glyph decoder. `code` drives the decoder's `code` input unchanged: it holds the most recently pressed key and returns to 8'h00 when that key is released, which blanks the glyph.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered `ps2_clk` level changes (1..255).
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- `clk`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `ps2_clk`, in, 1: raw keyboard clock, asynchronous to `clk`, idles high.
- `ps2_data`, in, 1: raw keyboard data, asynchronous, idles high.
- `code`, out, 8: held scan code for the decoder. Value is 8'h00 when no key is held.
- `code_valid`, out, 1: one-cycle pulse when a non-extended make code is accepted. Repeats on typematic.
- `key_release`, out, 1: one-cycle pulse when a non-extended break sequence (F0, xx) completes.
- `frame_err`, out, 1: one-cycle pulse on parity error, bad stop bit, or timeout.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. The synchronized `ps2_clk` goes through a glitch filter, and a falling edge of the filtered level produces a one-cycle `fall` strobe. `ps2_data` is sampled (synchronized value) in the `fall` cycle.
- **Frame FSM.** States are IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. On `fall` with data=1, stay in IDLE with no error.
  - DATA: shift 8 bits LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the bit. Odd parity over data+parity is required. Go to STOP.
  - STOP: sampled 1 and parity OK means the byte is accepted. Otherwise pulse `frame_err` and discard the byte. Return to IDLE in either case.
- **Timeout.** In any state other than IDLE, a counter counts `clk` cycles since the last `fall`. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse `frame_err`, discard partial data, and clear the prefix flags.
- **Byte resolver.** Flags `ext` and `brk` are updated per accepted byte:
  - 8'hE0: set `ext`. No output.
  - 8'hF0: set `brk`. No output.
  - Other byte with `ext`=1: ignored (extended keys are not displayed). Clear both flags.
  - Other byte with `brk`=1 and `ext`=0: pulse `key_release`. If the byte equals `code`, set `code` to 8'h00; otherwise `code` is unchanged. Clear `brk`.
  - Otherwise (make code): set `code` to the byte and pulse `code_valid`.
- **Output exclusivity.** At most one of `code_valid`, `key_release`, `frame_err` is high in any cycle.

## Timing
- **Reset values.** All outputs are 0 and `code`=8'h00. FSM is in IDLE, flags are cleared, the timeout counter is 0, and the filtered clock level is 1. Reset is asynchronous.
- **Reset mid-frame.** Everything returns to reset values. The partial frame is lost and no pulse is generated.
- **Edge latency.** From a `ps2_clk` pin transition to `fall` is 2 (sync) + FILTER_LEN cycles.
- **Output latency.** `code`, `code_valid`, `key_release`, and `frame_err` are registered. They assert in the cycle after the `fall` that samples the stop bit (or after the timeout terminal count). `code` changes in the same cycle its pulse asserts.
- **Filter.** The filtered level toggles only after FILTER_LEN consecutive synchronized samples opposite to the current level. Shorter glitches are fully rejected.
- **Timeout vs. edge.** If `fall` occurs in the same cycle as the terminal count, `fall` wins and the counter resets.
- **Timeout counter width.** Width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Structure
- **Package `ps2_pkg`:**
  - Constants `PS2_EXT_PREFIX`=8'hE0, `PS2_BREAK_PREFIX`=8'hF0, `PS2_NO_KEY`=8'h00.
  - The frame FSM state enum (IDLE, DATA, PARITY, STOP).
- **Sub-module `ps2_clk_filter`:** the 2-flop synchronizer, the glitch filter, and `fall` strobe generation, parameterized by FILTER_LEN. The top level instantiates it once for `ps2_clk`. `ps2_data` uses a plain 2-flop synchronizer.

## Test plan
- **Make code.** Frame 8'h1C sent with correct parity at 12.5 kHz -> `code`=8'h1C and one `code_valid` pulse, one cycle after the stop-bit `fall`.
- **Break of held key.** Frames F0 then 1C after make 1C -> one `key_release` pulse and `code`=8'h00. `code_valid` never asserts.
- **Break of a different key.** Make 1C, make 32, then F0 32 -> `code`=8'h32 then 8'h00. F0 1C afterwards -> `key_release` pulse and `code` stays 8'h00.
- **Extended key ignored.** Frames E0 75 and E0 F0 75 while `code`=8'h15 -> `code` stays 8'h15 and no pulses.
- **Errors.** Frame 8'h24 with flipped parity -> `frame_err` pulse and `code` unchanged. 5 bits then an idle line for TIMEOUT_CYCLES -> `frame_err` pulse, FSM back in IDLE. The next valid 8'h24 is accepted.
- **Glitch and reset.** A `ps2_clk` low glitch of FILTER_LEN-1 cycles mid-frame -> no extra bit shifted. Asserting `rst` during bit 4 -> all outputs 0, and the following full frame 8'h1D decodes correctly.
